dmem_lsu: RTL and testbench

Load/store unit between the single-cycle core's execute stage and the word-organised data memory `dmem`. It accepts one load or store request per handshake, performs alignment checks and sign/zero extension, and turns byte/half-word stores into a read-modify-write so neighbouring bytes in the addressed word are never clobbered. It returns exactly one response per accepted request, with an error code.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 27 ++
 rtl/dmem_lsu.sv | 108 ++++++++++
 tb/tb_dmem_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state type, RV32I load/store funct3 codes and response error codes for dmem_lsu
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;
  localparam logic [1:0] ERR_OOR = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic; in funct3/addr_lo/word/wdata, out ld_data (extended load), st_word (merged store), misaligned
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic        misaligned
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = {addr_lo, 3'b000};
  assign shifted = word >> sh;
  assign b = shifted[7:0];
  assign h = addr_lo[1] ? word[31:16] : word[15:0];
  assign ld_data = funct3[1] ? word :
                   funct3[0] ? {{16{~funct3[2] & h[15]}}, h} :
                               {{24{~funct3[2] & b[7]}}, b};
  assign st_word = funct3[1] ? wdata :
                   funct3[0] ? (addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
                               (word & ~(32'h0000_00ff << sh)) | ({24'b0, wdata[7:0]} << sh);
  assign misaligned = funct3[1:0] == 2'b01 ? addr_lo[0] :
                      funct3[1:0] == 2'b10 ? |addr_lo : 1'b0;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit (req_* handshake in, rsp_* strobe out, mem_* word port to dmem) with RMW for byte/half stores
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_mask,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  st;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wd_q, ld_data, st_word;
  logic        mis, ill, oor;
  logic [1:0]  err;
  assign req_ready = st == IDLE;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_mask = 3'b010;
  assign ill = req_we ? !(req_funct3 == F3_SB || req_funct3 == F3_SH || req_funct3 == F3_SW)
                      : !(req_funct3 == F3_LB || req_funct3 == F3_LH || req_funct3 == F3_LW ||
                          req_funct3 == F3_LBU || req_funct3 == F3_LHU);
  assign oor = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign err = ill ? ERR_ILL : mis ? ERR_MIS : oor ? ERR_OOR : ERR_OK;
  lsu_align u_align (
    .funct3     (req_ready ? req_funct3 : f3_q),
    .addr_lo    (req_ready ? req_addr[1:0] : addr_q[1:0]),
    .word       (mem_rdata),
    .wdata      (wd_q),
    .ld_data    (ld_data),
    .st_word    (st_word),
    .misaligned (mis)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'b000;
      addr_q <= 32'b0;
      wd_q <= 32'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err <= ERR_OK;
      mem_wr_data <= 32'b0;
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
    end else begin
      case (st)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          addr_q <= req_addr;
          wd_q <= req_wdata;
          if (err != ERR_OK) begin
            st <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= err;
          end else if (req_we && req_funct3 == F3_SW) begin
            st <= WR;
            mem_wr <= 1'b1;
            mem_wr_data <= req_wdata;
          end else begin
            st <= RD;
            mem_rd <= 1'b1;
          end
        end
        RD: begin
          mem_rd <= 1'b0;
          if (we_q) begin
            st <= WR;
            mem_wr <= 1'b1;
            mem_wr_data <= st_word;
          end else begin
            st <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
          end
        end
        WR: begin
          st <= RESP;
          mem_wr <= 1'b0;
          mem_wr_data <= 32'b0;
          rsp_valid <= 1'b1;
        end
        default: begin
          st <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'b0;
          rsp_err <= ERR_OK;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized + directed self-checking bench for dmem_lsu against a cycle-scheduled behavioural model
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_addr, mem_wr_data, mem_rdata;
  logic        mem_wr, mem_rd;
  logic [2:0]  mem_mask;
  logic [31:0] dmem [64];
  logic [31:0] ref_mem [64];
  int vec = 0, errs = 0, cyc = 0, rsp_c = -1, rd_c = -1, wr_c = -1;
  int acc_cnt = 0, dut_rsp = 0, aborted = 0, wr_idx = 0;
  logic [31:0] e_addr = 32'b0, e_rdata = 32'b0, wr_d = 32'b0, last_rdata = 32'b0, last_wr = 32'b0;
  logic [1:0]  e_err = 2'b0, last_err = 2'b0;
  logic        exp_rdy;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(negedge clk) if (mem_wr) dmem[mem_addr[7:2]] = mem_wr_data;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit ill = we ? (f3 > 2) : (f3 == 3 || f3 > 5);
    int sz = int'(f3 % 4);
    bit mis = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    bit oor = (a / 4) >= 64;
    return ill ? 2'd2 : mis ? 2'd1 : oor ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] v;
    int off = int'(a % 4);
    if (f3 % 4 == 2) return w;
    if (f3 % 4 == 1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] wd, input logic [31:0] a);
    int off = int'(a % 4);
    logic [31:0] mask = (f3 == 1) ? 32'hFFFF : 32'hFF;
    if (f3 == 2) return wd;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wr_data", mem_wr_data, 32'd0);
      if (rsp_c >= cyc) aborted++;
      rsp_c = -1;
      rd_c = -1;
      wr_c = -1;
    end else begin
      exp_rdy = cyc > rsp_c;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_c));
      chk("mem_rd", 32'(mem_rd), 32'(cyc == rd_c));
      chk("mem_wr", 32'(mem_wr), 32'(cyc == wr_c));
      chk("mem_wr_data", mem_wr_data, cyc == wr_c ? wr_d : 32'd0);
      chk("mem_mask", 32'(mem_mask), 32'd2);
      if (cyc == rd_c || cyc == wr_c) chk("mem_addr", mem_addr, e_addr);
      if (cyc == rsp_c) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (rsp_valid) begin
        dut_rsp++;
        last_rdata = rsp_rdata;
        last_err = rsp_err;
      end
      if (cyc == wr_c) begin
        ref_mem[wr_idx] = wr_d;
        last_wr = mem_wr_data;
      end
      if (exp_rdy && req_valid) begin
        acc_cnt++;
        e_addr = {req_addr[31:2], 2'b00};
        e_err = m_err(req_we, req_funct3, req_addr);
        e_rdata = 32'd0;
        wr_idx = int'(req_addr[7:2]);
        if (e_err != 0) rsp_c = cyc + 1;
        else if (!req_we) begin
          rd_c = cyc + 1;
          rsp_c = cyc + 2;
          e_rdata = m_load(req_funct3, ref_mem[wr_idx], req_addr);
        end else if (req_funct3 == 2) begin
          wr_c = cyc + 1;
          rsp_c = cyc + 2;
          wr_d = req_wdata;
        end else begin
          rd_c = cyc + 1;
          wr_c = cyc + 2;
          rsp_c = cyc + 3;
          wr_d = m_store(req_funct3, ref_mem[wr_idx], req_wdata, req_addr);
        end
      end
    end
    cyc++;
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input bit keep);
    int n0 = acc_cnt;
    int t = 0;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    while (acc_cnt == n0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (acc_cnt == n0) begin
      errs++;
      $display("FAIL accept_timeout: got no accept want accept within 50 cycles");
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n0 = dut_rsp;
    int t = 0;
    while (dut_rsp == n0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (dut_rsp == n0) begin
      errs++;
      $display("FAIL rsp_timeout: got no rsp_valid want one within 20 cycles");
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    dmem[i] = v;
    ref_mem[i] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    preload(3, 32'h80FF_7F01);
    issue(1'b0, 3'b000, 32'h0D, 32'h0, 1'b0);
    wait_rsp();
    chk("lb_0d", last_rdata, 32'h0000_007F);
    issue(1'b0, 3'b000, 32'h0F, 32'h0, 1'b0);
    wait_rsp();
    chk("lb_0f", last_rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'b101, 32'h0E, 32'h0, 1'b0);
    wait_rsp();
    chk("lhu_0e", last_rdata, 32'h0000_80FF);
    preload(2, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h09, 32'h0000_00AB, 1'b0);
    wait_rsp();
    chk("sb_merge", last_wr, 32'h1122_AB44);
    issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    wait_rsp();
    chk("lw_after_sb", last_rdata, 32'h1122_AB44);
    preload(2, 32'h1122_3344);
    issue(1'b1, 3'b001, 32'h0A, 32'h0000_BEEF, 1'b0);
    wait_rsp();
    issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    wait_rsp();
    chk("lw_after_sh", last_rdata, 32'hBEEF_3344);
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
    wait_rsp();
    chk("sw_data", last_wr, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    wait_rsp();
    chk("err_mis", 32'(last_err), 32'd1);
    chk("err_mis_rdata", last_rdata, 32'd0);
    issue(1'b0, 3'b011, 32'h08, 32'h0, 1'b0);
    wait_rsp();
    chk("err_ill", 32'(last_err), 32'd2);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
    wait_rsp();
    chk("err_oor", 32'(last_err), 32'd3);
    for (int i = 0; i < 8; i++) issue(1'(i % 2), 3'b010, 32'(4 * (i + 20)), $urandom, i != 7);
    repeat (5) begin @(posedge clk); #1; end
    preload(2, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h09, 32'h0000_00AB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_rd", 32'(mem_rd), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    wait_rsp();
    chk("lw_after_abort", last_rdata, 32'h1122_3344);
    repeat (300) begin
      a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 255));
      issue(1'($urandom % 2), ($urandom % 8 == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
            a, $urandom, 1'($urandom % 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("rsp_per_accept", 32'(dut_rsp + aborted), 32'(acc_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
